param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO with valid/ready on both sides, first-word-fall-through output, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a peak-occupancy watermark. It is the standard DUT of the UVM testbench template, the first real block the template's test package drives. It is generalised in width and depth so one environment covers every configuration.

---
 rtl/param_sync_fifo_if.sv | 30 +++
 rtl/param_sync_fifo.sv | 90 +++++++++
 tb/tb_param_sync_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// Valid/ready handshake bundle for both sides of param_sync_fifo.
// The FIFO takes the slave view; the producer/consumer environment takes the master view.
interface param_sync_fifo_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, almost-full/empty
// flags, synchronous flush and a peak-occupancy watermark.
module param_sync_fifo #(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 16,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             peak_clr_i,
    param_sync_fifo_if.slave bus,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CNT_W-1:0] peak_o
);
    localparam int               AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  peak_q, peak_d;
    logic              push, pop;

    // Flags decode only registered state, so no input can glitch them.
    assign full_o         = (count_q == DEPTH_C);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign count_o        = count_q;
    assign peak_o         = peak_q;

    assign bus.in_ready   = !full_o;
    assign bus.out_valid  = !empty_o;
    assign bus.out_data   = mem_q[rd_ptr_q[AW-1:0]];

    assign push = bus.in_valid && !full_o;
    assign pop  = !empty_o && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        peak_d   = peak_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            peak_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE_C;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE_C;
            case ({push, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
            if (peak_clr_i || (count_d > peak_q)) peak_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            peak_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            peak_q   <= peak_d;
        end
    end

    // Storage is deliberately left untouched by reset and flush; only pointers matter.
    always_ff @(posedge clk) begin
        if (push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at DATA_W=32, DEPTH=16 defaults.
module tb_param_sync_fifo;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       peakClr;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almostFull;
    logic       almostEmpty;
    logic [4:0] peak;

    int compareCount  = 0;
    int mismatchCount = 0;

    param_sync_fifo_if #(.DATA_W(32)) bus ();

    param_sync_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .peak_clr_i     (peakClr),
        .bus            (bus),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almostFull),
        .almost_empty_o (almostEmpty),
        .peak_o         (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic ready,
                                 input logic doFlush, input logic doPeakClr);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.out_ready = ready;
        flush         = doFlush;
        peakClr       = doPeakClr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 0);
        checkOutput({tag, "_peak"}, 32'(peak), 0);
        checkOutput({tag, "_empty"}, 32'(empty), 1);
        checkOutput({tag, "_full"}, 32'(full), 0);
        checkOutput({tag, "_inReady"}, 32'(bus.in_ready), 1);
        checkOutput({tag, "_outValid"}, 32'(bus.out_valid), 0);
        checkOutput({tag, "_almostEmpty"}, 32'(almostEmpty), 1);
        checkOutput({tag, "_almostFull"}, 32'(almostFull), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        peakClr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        checkResetState("rstAsserted");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkResetState("idle");

        // Three pushes with consumer stalled
        applyStimulus(1, 32'h11, 0, 0, 0);
        checkOutput("p1_count", 32'(count), 1);
        checkOutput("p1_outValid", 32'(bus.out_valid), 1);
        checkOutput("p1_head", bus.out_data, 32'h11);
        applyStimulus(1, 32'h22, 0, 0, 0);
        checkOutput("p2_count", 32'(count), 2);
        checkOutput("p2_almostEmpty", 32'(almostEmpty), 1);
        applyStimulus(1, 32'h33, 0, 0, 0);
        checkOutput("p3_count", 32'(count), 3);
        checkOutput("p3_almostEmpty", 32'(almostEmpty), 0);
        checkOutput("p3_head", bus.out_data, 32'h11);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("flushA_count", 32'(count), 0);
        checkOutput("flushA_peak", 32'(peak), 0);

        // Fill to full, then refused push alongside a pop, then drain
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 32'(i), 0, 0, 0);
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkOutput("fill_almostFull", 32'(almostFull), (i + 1 >= 14) ? 1 : 0);
        end
        checkOutput("full_flag", 32'(full), 1);
        checkOutput("full_inReady", 32'(bus.in_ready), 0);
        checkOutput("full_head", bus.out_data, 0);
        applyStimulus(1, 32'h99, 1, 0, 0);
        checkOutput("fullPop_count", 32'(count), 15);
        checkOutput("fullPop_inReady", 32'(bus.in_ready), 1);
        for (int i = 1; i < 16; i++) begin
            checkOutput("drain_data", bus.out_data, 32'(i));
            applyStimulus(0, 0, 1, 0, 0);
        end
        checkOutput("drain_empty", 32'(empty), 1);
        checkOutput("drain_peak", 32'(peak), 16);

        // Streaming push+pop across two pointer wraps
        applyStimulus(0, 0, 0, 1, 0);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) checkOutput("stream_data", bus.out_data, 32'(100 + k - 1));
            applyStimulus(1, 32'(100 + k), 1, 0, 0);
            checkOutput("stream_count", 32'(count), 1);
        end
        checkOutput("stream_last", bus.out_data, 32'd139);
        checkOutput("stream_peak", 32'(peak), 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("stream_empty", 32'(empty), 1);

        // Flush beats a concurrent push and pop
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'(8'hA0 + i), 0, 0, 0);
        checkOutput("load5_count", 32'(count), 5);
        applyStimulus(1, 32'h55, 1, 1, 0);
        checkOutput("flushB_count", 32'(count), 0);
        checkOutput("flushB_empty", 32'(empty), 1);
        checkOutput("flushB_peak", 32'(peak), 0);
        applyStimulus(1, 32'hAA, 0, 0, 0);
        checkOutput("postFlush_head", bus.out_data, 32'hAA);
        checkOutput("postFlush_count", 32'(count), 1);

        // Watermark clear to the following count
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 32'(i), 0, 0, 0);
        checkOutput("load6_peak", 32'(peak), 6);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("pop2_count", 32'(count), 4);
        checkOutput("pop2_peak", 32'(peak), 6);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("peakClr_peak", 32'(peak), 4);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("peakClrPop_peak", 32'(peak), 3);
        checkOutput("peakClrPop_count", 32'(count), 3);

        // Asynchronous reset mid-stream, no clock edge needed
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("asyncRst");
        @(posedge clk);
        #1;
        checkOutput("rstHeld_count", 32'(count), 0);
        checkOutput("rstHeld_empty", 32'(empty), 1);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("afterRst_count", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
